// File: rtl/decrypt_function_1.sv
// Decrypt stage: rebuilds the 60-bit key from rand_11, recovers data = x - key,
// flags width violations, and counts erroneous words in a saturating counter.
module decrypt_function_1 #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [77:0]          inEnc,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [59:0]          data_out,
  output logic [5:0]           rand_6_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  function automatic logic [59:0] rebuild_key(input logic [10:0] r);
    return {r[4:0], ~r, r, ~r, ~r, r};
  endfunction

  logic                 adv_s;
  logic [61:0]          diff_s;
  logic                 err_s;

  logic                 s1_valid_q, s1_valid_d;
  logic [60:0]          x_q, x_d;
  logic [5:0]           r6_q, r6_d;
  logic [59:0]          key_q, key_d;
  logic                 out_valid_q, out_valid_d;
  logic [59:0]          data_q, data_d;
  logic [5:0]           r6o_q, r6o_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign adv_s    = !out_valid_q || out_ready;
  assign in_ready = adv_s;

  // Borrow lands in bit 61, an over-wide result in bit 60.
  assign diff_s = {1'b0, x_q} - {2'b00, key_q};
  assign err_s  = diff_s[61] | diff_s[60];

  // Stage 1 next state: capture packet fields and rebuilt key.
  always_comb begin
    s1_valid_d = s1_valid_q;
    x_d        = x_q;
    r6_d       = r6_q;
    key_d      = key_q;
    if (adv_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        x_d   = inEnc[77:17];
        r6_d  = inEnc[5:0];
        key_d = rebuild_key(inEnc[16:6]);
      end else begin
        x_d   = x_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: subtract and load output register and error counter.
  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    r6o_d       = r6o_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    if (adv_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d = diff_s[59:0];
        r6o_d  = r6_q;
        err_d  = err_s;
        if (err_s && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
          err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end else begin
        data_d = data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      x_q         <= 61'd0;
      r6_q        <= 6'd0;
      key_q       <= 60'd0;
      out_valid_q <= 1'b0;
      data_q      <= 60'd0;
      r6o_q       <= 6'd0;
      err_q       <= 1'b0;
      err_cnt_q   <= {ERR_CNT_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      x_q         <= x_d;
      r6_q        <= r6_d;
      key_q       <= key_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      r6o_q       <= r6o_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_q;
  assign rand_6_out = r6o_q;
  assign err        = err_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_decrypt_function_1.sv
// Randomized bench for decrypt_function_1 against an arithmetic reference model.
module tb_decrypt_function_1;
  localparam int W = 8;
  localparam int CNT_MAX = (1 << W) - 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [77:0]   inEnc;
  logic          in_valid;
  logic          in_ready;
  logic [59:0]   data_out;
  logic [5:0]    rand_6_out;
  logic          out_valid;
  logic          out_ready;
  logic          err;
  logic [W-1:0]  err_count;

  decrypt_function_1 #(.ERR_CNT_W(W)) dut (
    .Clk(Clk), .Reset(Reset), .inEnc(inEnc), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .rand_6_out(rand_6_out),
    .out_valid(out_valid), .out_ready(out_ready), .err(err),
    .err_count(err_count)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [59:0] d; logic [5:0] r6; logic e; } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   errs_seen = 0;
  logic ov_m = 1'b0;
  logic s1_m = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Key from spec: 11-bit segments r,~r,~r,r,~r then r[4:0]
  function automatic logic [63:0] key_of(input logic [10:0] r);
    logic [63:0] b = 64'd0;
    for (int i = 0; i < 60; i++) begin
      int seg = i / 11;
      logic inv = (seg == 1) || (seg == 2) || (seg == 4);
      b[i] = r[i % 11] ^ inv;
    end
    return b;
  endfunction

  function automatic logic [77:0] encode(input logic [59:0] d, input logic [10:0] r11, input logic [5:0] r6);
    logic [63:0] x = {4'd0, d} + key_of(r11);
    return {x[60:0], r11, r6};
  endfunction

  function automatic exp_t expect_of(input logic [77:0] enc);
    exp_t o;
    logic [63:0] xv = {3'd0, enc[77:17]};
    logic [63:0] bv = key_of(enc[16:6]);
    logic [63:0] dv = xv - bv;
    o.d  = dv[59:0];
    o.r6 = enc[5:0];
    o.e  = (xv < bv) || (dv >= 64'h1000_0000_0000_0000);
    return o;
  endfunction

  // One clock: drive inputs, check visible state, update model, advance.
  task automatic step(input logic iv, input logic [77:0] enc, input logic ordy, output logic acc);
    logic adv;
    exp_t f;
    in_valid = iv; inEnc = enc; out_ready = ordy;
    #1;
    adv = !ov_m || ordy;
    chk("out_valid", {63'd0, out_valid}, {63'd0, ov_m});
    chk("in_ready", {63'd0, in_ready}, {63'd0, adv});
    if (ov_m) begin
      chk("sb_nonempty", {63'd0, q.size() != 0}, 64'd1);
      if (q.size() != 0) begin
        f = q[0];
        chk("data_out", {4'd0, data_out}, {4'd0, f.d});
        chk("rand_6_out", {58'd0, rand_6_out}, {58'd0, f.r6});
        chk("err", {63'd0, err}, {63'd0, f.e});
        if (ordy) begin
          void'(q.pop_front());
          if (f.e) errs_seen++;
          chk("err_count", {{(64-W){1'b0}}, err_count},
              64'((errs_seen > CNT_MAX) ? CNT_MAX : errs_seen));
        end
      end
    end
    acc = iv && adv;
    if (acc) q.push_back(expect_of(enc));
    if (adv) begin ov_m = s1_m; s1_m = iv; end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 4; i++) step(1'b0, 78'd0, 1'b1, a);
  endtask

  logic        acc;
  logic [77:0] pend;
  logic        have_pend;
  int          idx;
  int          cyc;

  initial begin
    Reset = 1'b1; in_valid = 1'b0; inEnc = 78'd0; out_ready = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data_out", {4'd0, data_out}, 64'd0);
    chk("rst_rand_6_out", {58'd0, rand_6_out}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_err_count", {{(64-W){1'b0}}, err_count}, 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Round trip, carry case, corrupt packet
    step(1'b1, encode(60'h123_4567_89AB_CDEF, 11'h5A5, 6'h2A), 1'b1, acc);
    step(1'b0, 78'd0, 1'b1, acc);
    chk("rt_data", {4'd0, data_out}, 64'h0123_4567_89AB_CDEF);
    chk("rt_err", {63'd0, err}, 64'd0);
    step(1'b1, encode(60'hFFF_FFFF_FFFF_FFFF, 11'h7FF, 6'h15), 1'b1, acc);
    step(1'b0, 78'd0, 1'b1, acc);
    chk("carry_data", {4'd0, data_out}, 64'h0FFF_FFFF_FFFF_FFFF);
    step(1'b1, {61'd0, 11'h000, 6'h3F}, 1'b1, acc);
    step(1'b0, 78'd0, 1'b1, acc);
    chk("corrupt_data", {4'd0, data_out}, (64'h1000_0000_0000_0000 - key_of(11'h000)) & 64'h0FFF_FFFF_FFFF_FFFF);
    chk("corrupt_cnt", {{(64-W){1'b0}}, err_count}, 64'd1);
    drain();

    // 8 back-to-back words with a 3-cycle stall mid-stream
    idx = 0; cyc = 0;
    while (idx < 8 && cyc < 40) begin
      step(1'b1, encode({$urandom, $urandom}, 11'(idx * 77), 6'(idx)),
           !(cyc >= 3 && cyc < 6), acc);
      if (acc) idx++;
      cyc++;
    end
    chk("stream_accepted", 64'(idx), 64'd8);
    drain();
    chk("stream_drained", 64'(q.size()), 64'd0);

    // Randomized traffic with random backpressure
    have_pend = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!have_pend) begin
        if ($urandom_range(0, 4) == 0) pend = 78'({$urandom, $urandom, $urandom});
        else pend = encode({$urandom, $urandom}, 11'($urandom), 6'($urandom));
        have_pend = 1'b1;
      end
      step($urandom_range(0, 3) != 0, pend, $urandom_range(0, 3) != 0, acc);
      if (acc) have_pend = 1'b0;
    end
    drain();

    // Reset between edges with two corrupt words in flight
    step(1'b1, {61'd0, 11'h001, 6'h01}, 1'b1, acc);
    step(1'b1, {61'd0, 11'h002, 6'h02}, 1'b1, acc);
    in_valid = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_err", {63'd0, err}, 64'd0);
    chk("mid_rst_err_count", {{(64-W){1'b0}}, err_count}, 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    q.delete(); ov_m = 1'b0; s1_m = 1'b0; errs_seen = 0;
    drain();

    // Saturation: 260 corrupt words
    for (int i = 0; i < 260; i++) step(1'b1, {61'd0, 11'(i), 6'(i)}, 1'b1, acc);
    drain();
    chk("sat_count", {{(64-W){1'b0}}, err_count}, 64'(CNT_MAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decrypt_function_1.md
Name: decrypt_function_1

Overview:
Downstream consumer of the 78-bit encrypted packet produced by the encrypt stage. Packet layout is [77:17] masked sum x (61 b), [16:6] rand_11, [5:0] rand_6.
The block regenerates the 60-bit key b from rand_11, recovers data = x - b, and checks that the result is consistent.
It is a 2-stage valid/ready pipeline with whole-pipe stall on backpressure, plus a saturating error counter.

Parameters:
ERR_CNT_W, 8, width of the saturating error counter

Ports:
Clk  input  1  clock; all state updates on posedge
Reset  input  1  asynchronous, active-high reset
inEnc  input  78  encrypted packet, layout as above
in_valid  input  1  inEnc is valid this cycle
in_ready  output  1  block accepts inEnc this cycle
data_out  output  60  recovered plaintext
rand_6_out  output  6  rand_6 field passed through
out_valid  output  1  data_out, rand_6_out and err are valid
out_ready  input  1  downstream accepts the output this cycle
err  output  1  current output word failed the integrity check
err_count  output  ERR_CNT_W  saturating count of erroneous words delivered

Behaviour:
- Reset (async, Reset=1): all valid bits, data_out, rand_6_out, err and err_count clear to 0. Asserting Reset mid-operation discards any in-flight words, with no partial output.
- Key rebuild from r = rand_11:
  - b[10:0] = r
  - b[21:11] = ~r
  - b[32:22] = ~r
  - b[43:33] = r
  - b[54:44] = ~r
  - b[59:55] = r[4:0]
- Advance condition: adv = !out_valid || out_ready. in_ready = adv, which is combinational from out_valid and out_ready only.
- Transfer: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stage 1, on adv: s1_valid <= in_valid. When in_valid, register x = inEnc[77:17], rand_6 = inEnc[5:0], and key b rebuilt from inEnc[16:6].
- Stage 2 (output register), on adv: out_valid <= s1_valid. When s1_valid:
  - diff (62 b) = {1'b0, x} - {2'b0, b}
  - data_out <= diff[59:0]
  - rand_6_out <= rand_6
  - err <= diff[61] | diff[60], i.e. a borrow (x < b) or a result wider than 60 bits
- Latency: 2 cycles from input transfer to out_valid, with no bubbles. Sustained throughput is 1 word/clk while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, all pipeline registers hold and in_ready=0. in_valid and inEnc are ignored, and the upstream holds its word.
- Simultaneous output transfer and new input in the same cycle: both happen, and the pipeline shifts by one.
- Output stability: outputs are stable while out_valid && !out_ready.
- err_count: increments by 1 on each cycle where stage 2 loads a word with err=1 (i.e. adv && s1_valid && computed err). It saturates at 2^ERR_CNT_W - 1 and does not wrap. Cleared only by Reset.
- Error words are still delivered: data_out carries diff[59:0] truncated, with err=1. No word is dropped.
- x[60] = 1 with a valid key is legal (it is the carry of data+b). Only a post-subtract width violation flags err.

Test Plan:
- Round trip: encode data=60'h123_4567_89AB_CDEF, rand_11=11'h5A5, rand_6=6'h2A with the encrypt rule (x = data+b) → 2 cycles later out_valid=1, data_out=60'h123456789ABCDEF, rand_6_out=6'h2A, err=0.
- Carry case: data=60'hFFF_FFFF_FFFF_FFFF, rand_11=11'h7FF (x[60]=1) → data_out=60'hFFFFFFFFFFFFFFF, err=0.
- Corrupt packet: inEnc with x=0, rand_11=11'h000 (b≠0, so x<b) → err=1, err_count=1, data_out=(2^60 - b) mod 2^60.
- Streaming with backpressure: 8 back-to-back valid words; out_ready held low for 3 cycles mid-stream → in_ready=0 during the stall, outputs held stable, all 8 words delivered in order with no loss or duplication.
- Saturation: 260 corrupt words with ERR_CNT_W=8 → err_count stops at 255.
- Reset mid-stream: assert Reset asynchronously between clock edges while 2 words are in flight → out_valid, err and err_count drop to 0 immediately, and no stale word appears after release.
